// File: rtl/riscv_pkg.sv
// Shared RISC-V core types.
// Fetch/decode bundle and address/word typedefs.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Flush discards contents and any same-cycle push/pop.
module sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Flush,
    input  logic          i_Push,
    input  T              i_Data,
    input  logic          i_Pop,
    output T              o_Data,
    output logic [CW-1:0] o_Count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = i_Pop && !empty;
    assign do_push = i_Push && (!full || do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset || i_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads zero.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !i_Flush) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    assign o_Data  = mem[rd_ptr];
    assign o_Count = count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC, credit-based issue,
// response buffering and redirect squash toward decode.
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter addr_t RESET_PC        = 32'h0000_0000,
    parameter int    FIFO_DEPTH      = 4,
    parameter int    MAX_OUTSTANDING = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Branch,
    input  logic [31:0] i_BranchAddress,
    output logic        o_MemReqValid,
    output logic [31:0] o_MemReqAddr,
    input  logic        i_MemReqReady,
    input  logic        i_MemRespValid,
    input  logic [31:0] i_MemRespData,
    output logic        o_Valid,
    output logic [31:0] o_Instruction,
    output logic [31:0] o_PC,
    output logic [31:0] o_NextPC,
    input  logic        i_Ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    addr_t         fetch_pc;
    addr_t         br_target;
    addr_t         resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_count;
    logic [OW-1:0] pcq_count;
    logic [CW-1:0] fifo_count;
    logic [31:0]   in_use;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          accept;
    logic          resp_live;
    logic          pop;

    assign br_target = i_BranchAddress & ~addr_t'(3);

    // Slots already promised: buffered plus live in-flight.
    assign in_use = 32'(fifo_count) + 32'(outstanding)
                  - 32'(drop_count);

    assign o_MemReqValid = i_Reset && !i_Branch
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (in_use < 32'(FIFO_DEPTH));
    assign o_MemReqAddr  = fetch_pc;

    assign accept    = o_MemReqValid && i_MemReqReady;
    assign resp_live = i_MemRespValid && (drop_count == '0)
                    && !i_Branch;
    assign pop       = o_Valid && i_Ready;

    assign push_entry = '{pc: resp_pc, instr: i_MemRespData};

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_entry_q (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Flush (i_Branch),
        .i_Push  (resp_live),
        .i_Data  (push_entry),
        .i_Pop   (pop),
        .o_Data  (head),
        .o_Count (fifo_count)
    );

    sync_fifo #(
        .T     (addr_t),
        .DEPTH (MAX_OUTSTANDING),
        .CW    (OW)
    ) u_pc_q (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Flush (i_Branch),
        .i_Push  (accept),
        .i_Data  (fetch_pc),
        .i_Pop   (resp_live),
        .o_Data  (resp_pc),
        .o_Count (pcq_count)
    );

    assign o_Valid       = (fifo_count != '0);
    assign o_PC          = head.pc;
    assign o_Instruction = head.instr;
    assign o_NextPC      = o_Valid ? head.pc + 32'(INSTR_BYTES) : '0;

    // Fetch PC: redirect wins over sequential advance.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            fetch_pc <= RESET_PC;
        end else if (i_Branch) begin
            fetch_pc <= br_target;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        end
    end

    // In-flight count and stale-response squash count.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept)
                         - OW'(i_MemRespValid);
            if (i_Branch) begin
                drop_count <= outstanding - OW'(i_MemRespValid);
            end else if (i_MemRespValid && drop_count != '0) begin
                drop_count <= drop_count - OW'(1);
            end
        end
    end

    // Counter invariants and illegal unsolicited responses.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            assert (outstanding <= OW'(MAX_OUTSTANDING));
            assert (drop_count <= outstanding);
            assert (fifo_count <= CW'(FIFO_DEPTH));
            assert (!i_MemRespValid || outstanding != '0);
            assert (pcq_count == outstanding - drop_count);
        end
    end

endmodule
